updown_mod_counter: RTL and testbench

UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

---
 rtl/updown_mod_counter.sv | 72 +++++++
 tb/tb_updown_mod_counter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/updown_mod_counter.sv
// Up/down modulo-MODULUS counter with synchronous load, wrap pulse and sticky overflow flag.
// Define COUNTER_SATURATE_EN to hold at the boundary instead of wrapping around.
module updown_mod_counter #(
    parameter int WIDTH     = 5,
    parameter int MODULUS   = 32,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             at_top, at_bottom;

    assign at_top    = (q_q == MAX_VAL);
    assign at_bottom = (q_q == '0);

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        ovf_d  = ovf_q;
        if (load) begin
            // Out-of-range load values clamp to the top count state.
            q_d   = (load_val > MAX_VAL) ? MAX_VAL : load_val;
            ovf_d = 1'b0;
        end else if (en) begin
            if ((up && at_top) || (!up && at_bottom)) begin
                wrap_d = 1'b1;
                ovf_d  = 1'b1;
`ifdef COUNTER_SATURATE_EN
                q_d    = q_q;
`else
                q_d    = up ? '0 : MAX_VAL;
`endif
            end else if (up) begin
                q_d = q_q + ONE;
            end else begin
                q_d = q_q - ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q    <= RST_VAL;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    assign q    = q_q;
    assign wrap = wrap_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench for updown_mod_counter (WIDTH=5, MODULUS=10, RESET_VAL=0).
// Stimulus pushes hand-computed {q,wrap,ovf} per edge; a monitor pops and compares after each edge.
module tb_updown_mod_counter;

    logic       clk;
    logic       reset;
    logic       en;
    logic       up;
    logic       load;
    logic [4:0] load_val;
    logic [4:0] q;
    logic       wrap;
    logic       ovf;

    int n_vec  = 0;
    int n_fail = 0;

    logic [6:0] sb[$];

    updown_mod_counter #(
        .WIDTH    (5),
        .MODULUS  (10),
        .RESET_VAL(0)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .up      (up),
        .load    (load),
        .load_val(load_val),
        .q       (q),
        .wrap    (wrap),
        .ovf     (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input logic r, input logic e, input logic u, input logic l,
                        input logic [4:0] lv, input logic [4:0] eq,
                        input logic ew, input logic eo);
        @(negedge clk);
        reset    = r;
        en       = e;
        up       = u;
        load     = l;
        load_val = lv;
        sb.push_back({eq, ew, eo});
    endtask

    // Monitor: one expected entry is pending per applied edge.
    initial begin
        logic [6:0] exp_v;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                exp_v = sb.pop_front();
                n_vec++;
                if ({q, wrap, ovf} !== exp_v) begin
                    n_fail++;
                    $display("FAIL vec%0d q/wrap/ovf: got q=%0d wrap=%b ovf=%b, expected q=%0d wrap=%b ovf=%b",
                             n_vec, q, wrap, ovf, exp_v[6:2], exp_v[1], exp_v[0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;

        // reset for two cycles
        step(1, 0, 1, 0, 0, 5'd0, 0, 0);
        step(1, 0, 1, 0, 0, 5'd0, 0, 0);

`ifdef COUNTER_SATURATE_EN
        step(0, 0, 1, 1, 5'd8, 5'd8, 0, 0);
        step(0, 1, 1, 0, 0, 5'd9, 0, 0);
        step(0, 1, 1, 0, 0, 5'd9, 1, 1);
        step(0, 1, 1, 0, 0, 5'd9, 1, 1);
        step(0, 1, 1, 0, 0, 5'd9, 1, 1);
        step(0, 1, 0, 0, 0, 5'd8, 0, 1);
        step(0, 0, 0, 1, 5'd0, 5'd0, 0, 0);
        step(0, 1, 0, 0, 0, 5'd0, 1, 1);
        step(0, 1, 0, 0, 0, 5'd0, 1, 1);
        step(0, 0, 0, 0, 0, 5'd0, 0, 1);
        step(0, 1, 1, 0, 0, 5'd1, 0, 1);
        step(0, 0, 0, 1, 5'd20, 5'd9, 0, 0);
        step(1, 1, 1, 1, 5'd3, 5'd0, 0, 0);
`else
        // count up through the wrap
        for (int i = 1; i <= 9; i++) step(0, 1, 1, 0, 0, 5'(i), 0, 0);
        step(0, 1, 1, 0, 0, 5'd0, 1, 1);
        step(0, 1, 1, 0, 0, 5'd1, 0, 1);
        step(0, 1, 1, 0, 0, 5'd2, 0, 1);

        // reset then count down through the bottom
        step(1, 1, 1, 0, 0, 5'd0, 0, 0);
        step(0, 1, 0, 0, 0, 5'd9, 1, 1);
        step(0, 1, 0, 0, 0, 5'd8, 0, 1);
        step(0, 1, 0, 0, 0, 5'd7, 0, 1);
        step(0, 1, 0, 0, 0, 5'd6, 0, 1);
        step(0, 1, 0, 0, 0, 5'd5, 0, 1);
        step(0, 1, 0, 0, 0, 5'd4, 0, 1);

        // load beats en and clears ovf; direction changes without dead cycle
        step(0, 1, 1, 1, 5'd7, 5'd7, 0, 0);
        step(0, 1, 1, 0, 0, 5'd8, 0, 0);
        step(0, 1, 0, 0, 0, 5'd7, 0, 0);
        step(0, 1, 1, 0, 0, 5'd8, 0, 0);
        step(0, 0, 1, 0, 0, 5'd8, 0, 0);

        // out-of-range load clamps to 9
        step(0, 0, 1, 1, 5'd15, 5'd9, 0, 0);
        step(0, 1, 1, 0, 0, 5'd0, 1, 1);
        step(0, 0, 0, 0, 0, 5'd0, 0, 1);
        step(0, 0, 1, 1, 5'd10, 5'd9, 0, 0);
        step(0, 0, 1, 1, 5'd9, 5'd9, 0, 0);

        // reach 5 with ovf set, then reset beats load and en
        step(0, 1, 1, 0, 0, 5'd0, 1, 1);
        for (int i = 1; i <= 5; i++) step(0, 1, 1, 0, 0, 5'(i), 0, 1);
        step(1, 1, 1, 1, 5'd3, 5'd0, 0, 0);
        step(0, 1, 1, 0, 0, 5'd1, 0, 0);
        step(0, 1, 1, 0, 0, 5'd2, 0, 0);
`endif

        @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left in scoreboard, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
